// File: rtl/tea_pkg.sv
// tea_pkg: shared encodings and helpers for the TEA cipher core.
package tea_pkg;
   localparam logic MODE_ENC = 1'b0;
   localparam logic MODE_DEC = 1'b1;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   // Starting sum for decryption: delta advanced by every round, kept to w bits.
   function automatic logic [63:0] tea_sum_init(input logic [63:0] delta, input int rounds, input int w);
      logic [63:0] p;
      p = delta * 64'(rounds);
      return (w >= 64) ? p : p & ((64'd1 << w) - 64'd1);
   endfunction
endpackage

// File: rtl/tea_cipher_core_round.sv
// tea_round: one combinational TEA Feistel cycle, encrypt or decrypt.
module tea_round import tea_pkg::*; #(
   parameter int W = 32
) (
   input  logic [W-1:0] v0,
   input  logic [W-1:0] v1,
   input  logic [W-1:0] sum,
   input  logic [W-1:0] k0,
   input  logic [W-1:0] k1,
   input  logic [W-1:0] k2,
   input  logic [W-1:0] k3,
   input  logic [W-1:0] delta,
   input  logic         mode,
   output logic [W-1:0] v0_next,
   output logic [W-1:0] v1_next,
   output logic [W-1:0] sum_next
);
   function automatic logic [W-1:0] mix(input logic [W-1:0] v, s, ka, kb);
      return ((v << 4) + ka) ^ (v + s) ^ ((v >> 5) + kb);
   endfunction
   logic [W-1:0] s_enc, e0, d1;
   // Encrypt advances sum first; decrypt uses the current sum and retreats after.
   always_comb begin
      s_enc    = sum + delta;
      e0       = v0 + mix(v1, s_enc, k0, k1);
      d1       = v1 - mix(v0, sum, k2, k3);
      v0_next  = (mode == MODE_DEC) ? v0 - mix(d1, sum, k0, k1) : e0;
      v1_next  = (mode == MODE_DEC) ? d1 : v1 + mix(e0, s_enc, k2, k3);
      sum_next = (mode == MODE_DEC) ? sum - delta : s_enc;
   end
endmodule

// File: rtl/tea_cipher_core.sv
// tea_cipher_core: parametrised TEA encrypt/decrypt engine with valid/ready
// handshakes, UNROLL rounds per clock.
module tea_cipher_core import tea_pkg::*; #(
   parameter int          W         = 32,
   parameter int          ROUNDS    = 32,
   parameter int          UNROLL    = 1,
   parameter logic [31:0] DELTA_DEF = 32'h9E3779B9
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic           mode,
   input  logic [4*W-1:0] key,
   input  logic           delta_sel,
   input  logic [W-1:0]   delta_in,
   input  logic [2*W-1:0] wdata,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [2*W-1:0] rdata,
   output logic           busy
);
   localparam int STEPS = ROUNDS / UNROLL;
   localparam int CW    = $clog2(STEPS + 1);
   state_t         state;
   logic [W-1:0]   v0, v1, sum, delta_r, din;
   logic [4*W-1:0] key_r;
   logic           mode_r;
   logic [CW-1:0]  cnt;
   logic [W-1:0]   cv0 [UNROLL+1];
   logic [W-1:0]   cv1 [UNROLL+1];
   logic [W-1:0]   cs  [UNROLL+1];
   assign din    = delta_sel ? delta_in : W'(DELTA_DEF);
   assign cv0[0] = v0;
   assign cv1[0] = v1;
   assign cs[0]  = sum;
   genvar i;
   generate
      for (i = 0; i < UNROLL; i++) begin : g_round
         tea_round #(.W(W)) u_round (
            .v0(cv0[i]), .v1(cv1[i]), .sum(cs[i]),
            .k0(key_r[W-1:0]), .k1(key_r[2*W-1:W]), .k2(key_r[3*W-1:2*W]), .k3(key_r[4*W-1:3*W]),
            .delta(delta_r), .mode(mode_r),
            .v0_next(cv0[i+1]), .v1_next(cv1[i+1]), .sum_next(cs[i+1])
         );
      end
   endgenerate
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         rdata     <= '0;
         cnt       <= '0;
         sum       <= '0;
         v0        <= '0;
         v1        <= '0;
         key_r     <= '0;
         mode_r    <= MODE_ENC;
         delta_r   <= '0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               v0       <= wdata[W-1:0];
               v1       <= wdata[2*W-1:W];
               key_r    <= key;
               mode_r   <= mode;
               delta_r  <= din;
               cnt      <= CW'(STEPS);
               sum      <= (mode == MODE_DEC) ? W'(tea_sum_init(64'(din), ROUNDS, W)) : '0;
               in_ready <= 1'b0;
               busy     <= 1'b1;
               state    <= RUN;
            end
            RUN: begin
               v0  <= cv0[UNROLL];
               v1  <= cv1[UNROLL];
               sum <= cs[UNROLL];
               cnt <= cnt - CW'(1);
               if (cnt == CW'(1)) begin
                  rdata     <= {cv1[UNROLL], cv0[UNROLL]};
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: if (out_ready) begin
               out_valid <= 1'b0;
               busy      <= 1'b0;
               in_ready  <= 1'b1;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_tea_cipher_core.sv
// tb_tea_cipher_core: directed vectors against an UNROLL=1 and an UNROLL=4 core.
module tb_tea_cipher_core;
   localparam logic [31:0] DEF = 32'h9E3779B9;
   logic         clk = 1'b0, rst;
   logic         in_valid, mode, delta_sel, out_ready;
   logic [127:0] key;
   logic [31:0]  delta_in;
   logic [63:0]  wdata;
   logic         in_ready1, out_valid1, busy1, in_ready4, out_valid4, busy4;
   logic [63:0]  rdata1, rdata4;
   int           nvec = 0, nerr = 0;
   always #5 clk = ~clk;

   tea_cipher_core #(.W(32), .ROUNDS(32), .UNROLL(1), .DELTA_DEF(DEF)) u1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .mode(mode), .key(key),
      .delta_sel(delta_sel), .delta_in(delta_in), .wdata(wdata), .out_valid(out_valid1),
      .out_ready(out_ready), .rdata(rdata1), .busy(busy1));
   tea_cipher_core #(.W(32), .ROUNDS(32), .UNROLL(4), .DELTA_DEF(DEF)) u4 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4), .mode(mode), .key(key),
      .delta_sel(delta_sel), .delta_in(delta_in), .wdata(wdata), .out_valid(out_valid4),
      .out_ready(out_ready), .rdata(rdata4), .busy(busy4));

   typedef struct {
      logic         m;
      logic [127:0] k;
      logic         ds;
      logic [31:0]  di;
      logic [63:0]  x;
      logic [63:0]  y;
   } vec_t;
   vec_t tbl[8];

   function automatic logic [63:0] model(input logic [63:0] v, input logic [127:0] k,
                                         input logic [31:0] d, input logic dec);
      logic [31:0] a, b, s;
      a = v[31:0];
      b = v[63:32];
      s = dec ? 32'(d * 32) : 32'h0;
      for (int r = 0; r < 32; r++) begin
         if (!dec) begin
            s = s + d;
            a = a + (((b << 4) + k[31:0]) ^ (b + s) ^ ((b >> 5) + k[63:32]));
            b = b + (((a << 4) + k[95:64]) ^ (a + s) ^ ((a >> 5) + k[127:96]));
         end else begin
            b = b - (((a << 4) + k[95:64]) ^ (a + s) ^ ((a >> 5) + k[127:96]));
            a = a - (((b << 4) + k[31:0]) ^ (b + s) ^ ((b >> 5) + k[63:32]));
            s = s - d;
         end
      end
      return {b, a};
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_v1(input string nm);
      for (int c = 0; c < 64 && !out_valid1; c++) tick();
      chk({nm, "_timeout"}, 64'(out_valid1), 64'd1);
   endtask

   task automatic run_block(input string nm, input logic m, input logic [127:0] k, input logic ds,
                            input logic [31:0] di, input logic [63:0] x, input logic [63:0] y);
      int l1, l4;
      mode = m; key = k; delta_sel = ds; delta_in = di; wdata = x;
      chk({nm, "_ready"}, {62'd0, in_ready1, in_ready4}, 64'd3);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      mode = ~m; key = ~k; delta_sel = ~ds; delta_in = ~di; wdata = ~x;
      chk({nm, "_busy"}, {62'd0, busy1, in_ready1}, 64'd2);
      l1 = 0; l4 = 0;
      for (int c = 2; c <= 64 && (l1 == 0 || l4 == 0); c++) begin
         tick();
         if (l1 == 0 && out_valid1) l1 = c;
         if (l4 == 0 && out_valid4) l4 = c;
      end
      chk({nm, "_lat1"}, 64'(l1), 64'd33);
      chk({nm, "_lat4"}, 64'(l4), 64'd9);
      chk({nm, "_rdata1"}, rdata1, y);
      chk({nm, "_rdata4"}, rdata4, y);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk({nm, "_ovalid_off"}, {62'd0, out_valid1, out_valid4}, 64'd0);
      chk({nm, "_idle"}, {62'd0, in_ready1, in_ready4}, 64'd3);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [127:0] k;
      logic [63:0]  x, y;
      logic [31:0]  d;
      logic         ds;
      rst = 1'b1; in_valid = 1'b0; mode = 1'b0; delta_sel = 1'b0; out_ready = 1'b0;
      key = '0; delta_in = '0; wdata = '0;
      tbl[0] = '{1'b0, 128'h0, 1'b0, 32'h0, 64'h0, 64'h94BAA940_41EA3A0A};
      tbl[1] = '{1'b1, 128'h0, 1'b0, 32'h0, 64'h94BAA940_41EA3A0A, 64'h0};
      for (int i = 2; i < 8; i++) begin
         tbl[i].m  = i[0];
         tbl[i].k  = {$urandom, $urandom, $urandom, $urandom};
         tbl[i].ds = (i >= 5);
         tbl[i].di = 32'h12345678 + 32'(i);
         tbl[i].x  = {$urandom, $urandom};
         tbl[i].y  = model(tbl[i].x, tbl[i].k, tbl[i].ds ? tbl[i].di : DEF, tbl[i].m);
      end
      tick(); tick();
      chk("reset_state1", {in_ready1, out_valid1, busy1, rdata1}, {3'b100, 64'h0});
      chk("reset_state4", {in_ready4, out_valid4, busy4, rdata4}, {3'b100, 64'h0});
      rst = 1'b0;
      tick();
      for (int i = 0; i < 8; i++)
         run_block($sformatf("vec%0d", i), tbl[i].m, tbl[i].k, tbl[i].ds, tbl[i].di, tbl[i].x, tbl[i].y);
      for (int i = 0; i < 8; i++) begin
         x = {$urandom, $urandom};
         k = {$urandom, $urandom, $urandom, $urandom};
         ds = 1'($urandom_range(0, 1));
         d = $urandom;
         y = model(x, k, ds ? d : DEF, 1'b0);
         run_block($sformatf("rt_enc%0d", i), 1'b0, k, ds, d, x, y);
         run_block($sformatf("rt_dec%0d", i), 1'b1, k, ds, d, y, x);
      end
      // Backpressure: hold out_ready low with in_valid kept high.
      mode = 1'b0; key = '0; delta_sel = 1'b0; wdata = '0; in_valid = 1'b1;
      tick();
      wait_v1("bp");
      k = {$urandom, $urandom, $urandom, $urandom};
      x = {$urandom, $urandom};
      key = k; wdata = x;
      for (int c = 0; c < 10; c++) begin
         tick();
         chk($sformatf("bp_hold%0d", c), {out_valid1, in_ready1, in_ready4, rdata1},
             {3'b100, 64'h94BAA940_41EA3A0A});
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("bp_release", {61'd0, in_ready1, out_valid1, busy1}, 64'd4);
      tick();
      chk("bp_accept_next", {62'd0, busy1, in_ready1}, 64'd2);
      in_valid = 1'b0; mode = 1'b1; key = ~k; wdata = ~x;
      wait_v1("bp_next");
      chk("bp_next_rdata1", rdata1, model(x, k, DEF, 1'b0));
      chk("bp_next_rdata4", rdata4, model(x, k, DEF, 1'b0));
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      // Reset while round 7 is in progress.
      mode = 1'b0; key = '0; wdata = '0; delta_sel = 1'b0; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (6) tick();
      #2 rst = 1'b1;
      #1;
      chk("rst_run1", {in_ready1, out_valid1, busy1, rdata1}, {3'b100, 64'h0});
      chk("rst_run4", {in_ready4, out_valid4, busy4, rdata4}, {3'b100, 64'h0});
      tick();
      rst = 1'b0;
      k = {$urandom, $urandom, $urandom, $urandom};
      x = {$urandom, $urandom};
      run_block("after_rst_run", 1'b0, k, 1'b1, 32'h0BADF00D, x, model(x, k, 32'h0BADF00D, 1'b0));
      // Reset while the result waits in DONE.
      mode = 1'b0; key = '0; wdata = '0; delta_sel = 1'b0; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      wait_v1("rst_done");
      #2 rst = 1'b1;
      #1;
      chk("rst_done1", {in_ready1, out_valid1, busy1, rdata1}, {3'b100, 64'h0});
      chk("rst_done4", {in_ready4, out_valid4, busy4, rdata4}, {3'b100, 64'h0});
      tick();
      rst = 1'b0;
      run_block("after_rst_done", tbl[1].m, tbl[1].k, tbl[1].ds, tbl[1].di, tbl[1].x, tbl[1].y);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
